alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit registered arithmetic/logic unit for the single-cycle/multi-cycle CPU datapath in the team's processor labs.
- Takes two operands and a 3-bit operation code and produces a result plus carry, zero and signed-overflow flags.
- Outputs are captured one clock after the inputs and qualified by a valid pulse.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op are valid this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_Ctr  in  3  operation select.
- out_valid  out  1  registered in_valid; res and flags are updated when high.
- res  out  WIDTH  registered result.
- Co  out  1  registered carry/borrow-free flag.
- zero  out  1  registered (res == 0).
- overflow  out  1  registered signed overflow.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n is low, out_valid=0, res=0, Co=0, zero=1, overflow=0, asynchronously.
- Latency: fixed 1 cycle. Inputs sampled at a rising edge with in_valid=1 appear at the outputs after that edge.
- When in_valid=0, res and flags hold their previous values and out_valid=0.
- No backpressure; a new operation is accepted every cycle.
- Operation codes (ALU_Ctr):
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B.
  - 011 XOR: A ^ B.
  - 100 NOR: ~(A | B).
  - 101 SRL: A >> B[4:0], logical, zero fill.
  - 110 SUB: A - B.
  - 111 SLT: 1 if signed(A) < signed(B), else 0, zero-extended.
- Co:
  - ADD: carry out of bit WIDTH-1.
  - SUB: carry out of A + ~B + 1, i.e. 1 when A >= B unsigned.
  - All other ops: 0.
- overflow:
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B have different signs and the result sign differs from A.
  - All other ops: 0.
- SLT must use the true signed comparison (sub sign XOR sub overflow), correct even when the subtraction overflows.
- zero is computed from the next result value and registered alongside it.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH.
- SRL by 0 returns A unchanged; shift amounts 1..31 only, upper B bits are ignored.
- Reset asserted mid-operation discards the in-flight result; the first valid input after release produces out_valid one cycle later.

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- Defined: adds output ovf_sticky (1 bit), set on any out_valid cycle with overflow=1. It is cleared only by rst_n or by input ovf_clr (1 bit, synchronous, clear wins over a simultaneous set).
- Not defined: neither port exists; overflow is the only overflow indication.

Decomposition:
- Package alu_pkg holds the ALU_Ctr localparam encodings (OP_AND … OP_SLT) and the default WIDTH.
- One natural sub-module, alu_addsub: shared adder producing sum, carry out and overflow for ADD/SUB/SLT, with B inversion and carry-in 1 for subtraction.
- Result mux and flag registers stay in alu.

Test Plan:
- Reset, A=0, B=0, op 000: res=0, zero=1, Co=0, overflow=0, out_valid=0 during reset.
- A=AAAA0000, B=55550000, ops 000..011 one per cycle:
  - AND: res=00000000, zero=1.
  - OR: FFFF0000.
  - ADD: FFFF0000, Co=0, ovf=0.
  - XOR: FFFF0000.
- Same operands, ops 100..111:
  - NOR: 0000FFFF.
  - SRL: AAAA0000.
  - SUB: 55550000, Co=1, overflow=1.
  - SLT: 00000001.
- Overflow boundaries:
  - ADD 7FFFFFFF+00000001: 80000000, overflow=1, Co=0.
  - ADD FFFFFFFF+00000001: 0, Co=1, zero=1, overflow=0.
- Hold and shift: in_valid=0 for 3 cycles leaves outputs unchanged and out_valid=0. SRL A=80000000, B=0000001F gives 00000001.
- Sticky overflow (ALU_STICKY_OVF_EN): overflow event sets ovf_sticky, it stays set across clean ops, and ovf_clr clears it next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encodings and default operand width
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared adder for ADD/SUB/SLT with carry out and signed overflow
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = total[WIDTH-1:0];
    co    = total[WIDTH];
    // Operands of the effective addition share a sign that the sum does not.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 32-bit ALU with carry/zero/overflow flags
// Optional sticky overflow output and clear input under ALU_STICKY_OVF_EN.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Ctr,
`ifdef ALU_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             Co,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] as_sum;
  logic             as_co;
  logic             as_ovf;
  logic             as_sub;

  logic [WIDTH-1:0] res_next;
  logic             co_next;
  logic             ovf_next;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] res_d, res_q;
  logic             co_d, co_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;

  assign as_sub = (ALU_Ctr == OP_SUB) || (ALU_Ctr == OP_SLT);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (A),
    .b   (B),
    .sub (as_sub),
    .sum (as_sum),
    .co  (as_co),
    .ovf (as_ovf)
  );

  always_comb begin
    res_next = '0;
    co_next  = 1'b0;
    ovf_next = 1'b0;
    case (ALU_Ctr)
      OP_AND: res_next = A & B;
      OP_OR:  res_next = A | B;
      OP_ADD: begin
        res_next = as_sum;
        co_next  = as_co;
        ovf_next = as_ovf;
      end
      OP_XOR: res_next = A ^ B;
      OP_NOR: res_next = ~(A | B);
      OP_SRL: res_next = A >> B[4:0];
      OP_SUB: begin
        res_next = as_sum;
        co_next  = as_co;
        ovf_next = as_ovf;
      end
      // Sign of the difference corrected by overflow gives the true signed less-than.
      OP_SLT: res_next = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      default: res_next = '0;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid;
    res_d       = res_q;
    co_d        = co_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      res_d  = res_next;
      co_d   = co_next;
      zero_d = (res_next == '0);
      ovf_d  = ovf_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      co_q        <= 1'b0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      co_q        <= co_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign Co        = co_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

`ifdef ALU_STICKY_OVF_EN
  logic ovf_sticky_d, ovf_sticky_q;

  // Set in the same cycle the overflowing result becomes visible; clear has priority.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q | (in_valid & ovf_next);
    if (ovf_clr) ovf_sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_ctr;
  logic        out_valid;
  logic [31:0] res;
  logic        co;
  logic        zero;
  logic        overflow;
`ifdef ALU_STICKY_OVF_EN
  logic        ovf_clr;
  logic        ovf_sticky;
`endif

  int n_cmp;
  int n_bad;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .ALU_Ctr   (alu_ctr),
`ifdef ALU_STICKY_OVF_EN
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky),
`endif
    .out_valid (out_valid),
    .res       (res),
    .Co        (co),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic [2:0] op);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    alu_ctr  = op;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] r, input logic c,
                            input logic z, input logic o);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".res"},   res, r);
    chk({tag, ".co"},    {31'b0, co}, {31'b0, c});
    chk({tag, ".zero"},  {31'b0, zero}, {31'b0, z});
    chk({tag, ".ovf"},   {31'b0, overflow}, {31'b0, o});
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    alu_ctr  = 3'b000;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.res",   res, 32'h0);
    chk("rst.co",    {31'b0, co}, 32'd0);
    chk("rst.zero",  {31'b0, zero}, 32'd1);
    chk("rst.ovf",   {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b000);
    expect_all("and", 32'h00000000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b001);
    expect_all("or",  32'hFFFF0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b010);
    expect_all("add", 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b011);
    expect_all("xor", 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b100);
    expect_all("nor", 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b101);
    expect_all("srl0", 32'hAAAA0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b110);
    expect_all("sub", 32'h55550000, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'hAAAA0000, 32'h55550000, 3'b111);
    expect_all("slt", 32'h00000001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00000005, 32'hFFFFFFFB, 3'b111);
    expect_all("slt_pos", 32'h00000000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h00000003, 32'h00000005, 3'b110);
    expect_all("sub_borrow", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 32'h7FFFFFFF, 32'h00000001, 3'b010);
    expect_all("add_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    chk("sticky.set", {31'b0, ovf_sticky}, 32'd1);
`endif
    drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b010);
    expect_all("add_wrap", 32'h00000000, 1'b1, 1'b1, 1'b0);
`ifdef ALU_STICKY_OVF_EN
    chk("sticky.hold", {31'b0, ovf_sticky}, 32'd1);
`endif

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h12345678 + i, 32'h9ABCDEF0, 3'(i + 1));
      chk("hold.valid", {31'b0, out_valid}, 32'd0);
      chk("hold.res",   res, 32'h00000000);
      chk("hold.co",    {31'b0, co}, 32'd1);
      chk("hold.zero",  {31'b0, zero}, 32'd1);
    end

    drive(1'b1, 32'h80000000, 32'h0000001F, 3'b101);
    expect_all("srl31", 32'h00000001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hF0000000, 32'hFFFFFFE4, 3'b101);
    expect_all("srl_upper", 32'h0F000000, 1'b0, 1'b0, 1'b0);

`ifdef ALU_STICKY_OVF_EN
    @(negedge clk);
    ovf_clr = 1'b1;
    drive(1'b1, 32'h00000001, 32'h00000001, 3'b010);
    chk("sticky.clr", {31'b0, ovf_sticky}, 32'd0);
    drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010);
    chk("sticky.clr_wins", {31'b0, ovf_sticky}, 32'd0);
    @(negedge clk);
    ovf_clr = 1'b0;
`endif

    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h00000010;
    b        = 32'h00000020;
    alu_ctr  = 3'b010;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", {31'b0, out_valid}, 32'd0);
    chk("midrst.res",   res, 32'h0);
    chk("midrst.zero",  {31'b0, zero}, 32'd1);
    @(posedge clk);
    #1;
    chk("midrst.held", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(1'b1, 32'h00000010, 32'h00000020, 3'b010);
    expect_all("post_rst", 32'h00000030, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    chk("post_rst.drop", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
